// File: rtl/sev_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment encoding,
// blank pattern and scan-timing helpers.
package sev_seg_pkg;

  typedef logic [6:0] seg_t;

  // Common-anode, active-low: every segment off.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Cycles per brightness sub-phase inside one digit slot.
  function automatic int sub_cycles(input int div, input int bright_w);
    return div >> bright_w;
  endfunction

  // Counter width able to hold 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Hex nibble to active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic seg_t hex2seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sev_seg_scan_ctrl_if.sv
// Datapath-side and pin-side signals of the scan controller, bundled so the
// board top can hand one connection to the controller.
interface sev_seg_scan_ctrl_if
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 3
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [NUM_DIGITS*4-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [BRIGHT_W-1:0]     brightness;

  seg_t                    Seg;
  logic                    DP;
  logic [NUM_DIGITS-1:0]   AN;
  logic [IDX_W-1:0]        scan_idx;

  // Datapath registers / board top side.
  modport master (
    output digits, dp, digit_en, lz_blank, brightness,
    input  Seg, DP, AN, scan_idx
  );

  // Scan controller side.
  modport slave (
    input  digits, dp, digit_en, lz_blank, brightness,
    output Seg, DP, AN, scan_idx
  );

endinterface

// File: rtl/sev_seg_tick_gen.sv
// Slot timing: a sub-phase counter nested inside a brightness phase counter.
// One full sweep of both is one digit slot; slot_tick marks its last cycle.
module sev_seg_tick_gen
  import sev_seg_pkg::*;
#(
  parameter int DIV      = 8,
  parameter int BRIGHT_W = 2
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                slot_tick,
  output logic [BRIGHT_W-1:0] phase
);

  localparam int SUB   = sub_cycles(DIV, BRIGHT_W);
  localparam int SUB_W = cnt_width(SUB);

  if ((DIV % (2 ** BRIGHT_W)) != 0 || SUB < 1) begin : g_div_chk
    $error("sev_seg_tick_gen: DIV=%0d is not a nonzero multiple of 2**BRIGHT_W", DIV);
  end

  logic [SUB_W-1:0]    sub_cnt_q, sub_cnt_d;
  logic [BRIGHT_W-1:0] phase_q, phase_d;
  logic                sub_wrap;

  // Advance sub-phase; step the PWM phase each time the sub-phase wraps.
  always_comb begin
    sub_wrap  = (sub_cnt_q == SUB_W'(SUB - 1));
    sub_cnt_d = sub_wrap ? '0 : sub_cnt_q + SUB_W'(1);
    phase_d   = sub_wrap ? phase_q + BRIGHT_W'(1) : phase_q;
    slot_tick = sub_wrap && (phase_q == '1);
  end

  // Counter state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sub_cnt_q <= '0;
      phase_q   <= '0;
    end else begin
      sub_cnt_q <= sub_cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scan controller with per-digit enable,
// decimal points, leading-zero blanking and PWM brightness. Inputs are
// snapshotted at each slot start so a digit never tears mid-slot.
module sev_seg_scan_ctrl
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BRIGHT_W   = 3
) (
  input logic               clk,
  input logic               resetn,
  sev_seg_scan_ctrl_if.slave bus
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_nd_chk
    $error("sev_seg_scan_ctrl: NUM_DIGITS=%0d outside 2..16", NUM_DIGITS);
  end

  logic                slot_tick;
  logic [BRIGHT_W-1:0] phase;

  sev_seg_tick_gen #(
    .DIV      (DIV),
    .BRIGHT_W (BRIGHT_W)
  ) u_tick (
    .clk       (clk),
    .resetn    (resetn),
    .slot_tick (slot_tick),
    .phase     (phase)
  );

  logic [NUM_DIGITS*4-1:0] digits_s_q, digits_s_d;
  logic [NUM_DIGITS-1:0]   dp_s_q, dp_s_d;
  logic [NUM_DIGITS-1:0]   en_s_q, en_s_d;
  logic                    lz_s_q, lz_s_d;
  logic [BRIGHT_W-1:0]     bright_s_q, bright_s_d;
  logic                    snap_pend_q, snap_pend_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic                    dead_q, dead_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    snap_en;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    lz_run;
  logic [3:0]              nib_cur;
  logic                    lit;

  // Snapshot inputs at each slot start, and once on the first cycle out of
  // reset so the opening slot has real data; step the scan index per slot.
  always_comb begin
    snap_en     = slot_tick || snap_pend_q;
    digits_s_d  = snap_en ? bus.digits     : digits_s_q;
    dp_s_d      = snap_en ? bus.dp         : dp_s_q;
    en_s_d      = snap_en ? bus.digit_en   : en_s_q;
    lz_s_d      = snap_en ? bus.lz_blank   : lz_s_q;
    bright_s_d  = snap_en ? bus.brightness : bright_s_q;
    snap_pend_d = 1'b0;
    dead_d      = slot_tick;
    scan_idx_d  = scan_idx_q;
    if (slot_tick) begin
      scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end
  end

  // Blank decision per digit, walking down from the most significant digit
  // so a disabled digit counts as a zero for leading-zero purposes.
  always_comb begin
    blank_vec = '0;
    lz_run    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run       = lz_run && (!en_s_q[i] || (digits_s_q[4*i +: 4] == 4'h0));
      blank_vec[i] = !en_s_q[i] || (lz_s_q && (i != 0) && lz_run);
    end
  end

  // Output stage: light the current digit during its PWM on-window, except
  // in the dead cycle right after a slot change (anti-ghosting).
  always_comb begin
    nib_cur  = digits_s_q[4*int'(scan_idx_q) +: 4];
    lit      = !dead_q && !blank_vec[scan_idx_q] && (phase <= bright_s_q);
    an_d     = '1;
    seg_d    = SEG_BLANK;
    dp_out_d = 1'b1;
    if (lit) begin
      an_d     = ~(NUM_DIGITS'(1) << scan_idx_q);
      seg_d    = hex2seg(nib_cur);
      dp_out_d = ~dp_s_q[scan_idx_q];
    end
  end

  // All controller state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      digits_s_q  <= '0;
      dp_s_q      <= '0;
      en_s_q      <= '0;
      lz_s_q      <= 1'b0;
      bright_s_q  <= '0;
      snap_pend_q <= 1'b1;
      scan_idx_q  <= '0;
      dead_q      <= 1'b0;
      seg_q       <= SEG_BLANK;
      dp_out_q    <= 1'b1;
      an_q        <= '1;
    end else begin
      digits_s_q  <= digits_s_d;
      dp_s_q      <= dp_s_d;
      en_s_q      <= en_s_d;
      lz_s_q      <= lz_s_d;
      bright_s_q  <= bright_s_d;
      snap_pend_q <= snap_pend_d;
      scan_idx_q  <= scan_idx_d;
      dead_q      <= dead_d;
      seg_q       <= seg_d;
      dp_out_q    <= dp_out_d;
      an_q        <= an_d;
    end
  end

  assign bus.Seg      = seg_q;
  assign bus.DP       = dp_out_q;
  assign bus.AN       = an_q;
  assign bus.scan_idx = scan_idx_q;

endmodule
